// File: rtl/switch_out_queue_pkg.sv
// Shared constants and width helpers for the switch output queue.
package switch_pkg;

    localparam int SW_DATA_W    = 8;
    localparam int SW_DEPTH     = 4;
    localparam int SW_NUM_PORTS = 4;

    // Occupancy must be able to represent every value from 0 up to and including DEPTH.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [$clog2(SW_DEPTH + 1)-1:0] count_t;

endpackage

// File: rtl/switch_out_queue_port_fifo.sv
// Single-port synchronous FIFO holding the queued words for one output port.
module port_fifo
    import switch_pkg::*;
#(
    parameter int DATA_W = SW_DATA_W,
    parameter int DEPTH  = SW_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [DATA_W-1:0]           i_din,
    output logic [DATA_W-1:0]           o_dout,
    output logic [count_w(DEPTH)-1:0]   o_count,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_err
);

    localparam int CW = count_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_err;

    logic              w_doPush;
    logic              w_doPop;

    // Full and empty come from the occupancy counter, so the pointers may wrap freely.
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    assign o_dout   = r_mem[r_rdPtr];
    assign o_count  = r_count;
    assign o_err    = r_err;

    // Storage, pointers, occupancy and the sticky empty-read flag; reset wipes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_din;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_pop && o_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_out_queue.sv
// Output stage of the switch: one FIFO per port, multicast all-or-nothing writes.
module switch_out_queue
    import switch_pkg::*;
#(
    parameter int DATA_W    = SW_DATA_W,
    parameter int DEPTH     = SW_DEPTH,
    parameter int NUM_PORTS = SW_NUM_PORTS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic [DATA_W-1:0]                     in_data,
    input  logic [NUM_PORTS-1:0]                  in_dest,
    output logic                                  in_ready,
    output logic [NUM_PORTS*DATA_W-1:0]           port_out,
    output logic [NUM_PORTS-1:0]                  port_ready,
    input  logic [NUM_PORTS-1:0]                  port_read,
    output logic [NUM_PORTS*count_w(DEPTH)-1:0]   port_count,
    output logic [NUM_PORTS-1:0]                  port_err
);

    localparam int CW = count_w(DEPTH);

    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;

    // A word is refused if any selected port is full; an empty mask is simply consumed.
    // Only registered fullness feeds this, so a same-cycle pop never frees the slot early.
    assign in_ready   = &(~(in_dest & w_full));
    assign w_push     = {NUM_PORTS{in_valid && in_ready}} & in_dest;
    assign port_ready = ~w_empty;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        port_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[gi]),
            .i_pop   (port_read[gi]),
            .i_din   (in_data),
            .o_dout  (port_out[gi*DATA_W +: DATA_W]),
            .o_count (port_count[gi*CW +: CW]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi]),
            .o_err   (port_err[gi])
        );
    end

endmodule
